// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// The round-robin index wrap uses an explicit compare because NUM_REQ need not be a power of two.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker. It scans the requests starting at rr_ptr,
// wrapping modulo NUM_REQ, and returns the first request it finds.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     pick,
  output logic               any_valid
);

  function automatic int wrap_add(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  // The scan runs from farthest to nearest offset, so the nearest valid request wins.
  always_comb begin
    pick      = '0;
    any_valid = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(int'(rr_ptr), k)]) begin
        pick = IDW'(wrap_add(int'(rr_ptr), k));
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port between NUM_REQ producers.
// Each grant lasts for up to MAX_BURST words. The arbiter stalls while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_t            state;
  logic [IDW-1:0]        owner;
  logic [IDW-1:0]        rr_ptr;
  logic [BCW-1:0]        burst_cnt;
  logic [IDW-1:0]        pick;
  logic                  any_valid;
  logic                  owner_valid;
  logic                  xfer;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign owner_valid = req_valid[owner];
  assign owner_data  = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
  assign xfer        = (state == ARB_GRANT) && owner_valid && !fifo_full;
  assign last_beat   = (burst_cnt == BCW'(MAX_BURST - 1));

  // A full FIFO holds the grant indefinitely. A producer that drops valid loses the grant at once.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (!owner_valid || (xfer && last_beat)) begin
            state  <= ARB_IDLE;
            rr_ptr <= IDW'(next_idx(int'(owner), NUM_REQ));
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[owner] = 1'b1;
    end
    fifo_wr_en = xfer;
    fifo_din   = (state == ARB_GRANT) ? owner_data : '0;
    grant_id   = (state == ARB_GRANT) ? owner : '0;
    busy       = (state == ARB_GRANT);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. Counted producers and a counted FIFO fill level drive
// the 4-requester DUT. A second DUT with 3 requesters is driven directly to test rr_ptr wrap.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant_id;
  logic            busy;

  logic [2:0]      rv3;
  logic [23:0]     rd3;
  logic [2:0]      rr3;
  logic            full3;
  logic            wr3;
  logic [7:0]      din3;
  logic [1:0]      gid3;
  logic            busy3;

  int              cnt [NR];
  logic [7:0]      base [NR];
  logic [7:0]      k [NR];
  int              occ;
  bit              track;
  bit              pop;
  logic [7:0]      logq [$];
  int              num_checks = 0;
  int              num_fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_prod
    assign req_valid[g]          = (cnt[g] != 0);
    assign req_data[g*DW +: DW]  = base[g] + k[g];
  end
  assign fifo_full = (occ >= DEPTH);

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) dut3 (
    .clk        (clk),
    .rst_       (rst_),
    .req_valid  (rv3),
    .req_data   (rd3),
    .req_ready  (rr3),
    .fifo_full  (full3),
    .fifo_wr_en (wr3),
    .fifo_din   (din3),
    .grant_id   (gid3),
    .busy       (busy3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Each producer pops its counter when it is accepted.
  // Each write is logged, and the FIFO fill level is updated when tracking is on.
  task automatic applyStimulus();
    logic [NR-1:0] rdy;
    logic          wr;
    logic [7:0]    d;
    rdy = req_ready;
    wr  = fifo_wr_en;
    d   = fifo_din;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy[i]) begin
        cnt[i]--;
        k[i]++;
      end
    end
    if (wr) logq.push_back(d);
    if (track) begin
      if (wr) occ++;
      if (pop) occ--;
    end
    pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkBeat(input string tag, input logic [1:0] id, input logic [7:0] d);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << id;
    checkOutput({tag, "_wr"}, fifo_wr_en, 1);
    checkOutput({tag, "_gid"}, grant_id, id);
    checkOutput({tag, "_din"}, fifo_din, d);
    checkOutput({tag, "_rdy"}, req_ready, exp_rdy);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wr"}, fifo_wr_en, 0);
    checkOutput({tag, "_rdy"}, req_ready, 0);
  endtask

  task automatic doReset();
    rst_ = 1'b1;
    applyStimulus();
    rst_ = 1'b0;
  endtask

  initial begin
    rst_ = 1'b1; rv3 = '0; rd3 = '0; full3 = 1'b0;
    track = 1'b0; pop = 1'b0; occ = 0;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0; k[i] = '0; base[i] = '0;
    end
    @(negedge clk);
    checkOutput("rst_wr", fifo_wr_en, 0);
    checkOutput("rst_rdy", req_ready, 0);
    checkOutput("rst_din", fifo_din, 0);
    checkOutput("rst_gid", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_busy3", busy3, 0);
    applyStimulus();
    rst_ = 1'b0;

    $display("[TB] single requester bursts");
    cnt[2] = 6; base[2] = 8'h20;
    checkIdle("t1_idle"); applyStimulus();
    for (int j = 0; j < 4; j++) begin
      checkBeat("t1_a", 2'd2, 8'h20 + 8'(j)); applyStimulus();
    end
    checkIdle("t1_bubble"); applyStimulus();
    for (int j = 0; j < 2; j++) begin
      checkBeat("t1_b", 2'd2, 8'h24 + 8'(j)); applyStimulus();
    end
    checkOutput("t1_drop_busy", busy, 1);
    checkOutput("t1_drop_wr", fifo_wr_en, 0);
    checkOutput("t1_drop_gid", grant_id, 2);
    applyStimulus();
    checkIdle("t1_end");

    $display("[TB] all requesters valid");
    doReset();
    logq.delete();
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 20; base[i] = 8'(i * 16); k[i] = '0;
    end
    checkIdle("t2_idle"); applyStimulus();
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        checkBeat("t2_beat", 2'(b % 4), 8'((b % 4) * 16 + (b / 4) * 4 + j));
        applyStimulus();
      end
      checkIdle("t2_bubble");
      if (b == 4) for (int i = 0; i < NR; i++) cnt[i] = 0;
      applyStimulus();
    end
    checkOutput("t2_logsize", logq.size(), 20);
    for (int n = 0; n < 20; n++) begin
      if (n < logq.size())
        checkOutput("t2_log", logq[n], ((n / 4) % 4) * 16 + (n / 16) * 4 + (n % 4));
    end

    $display("[TB] fifo full stall");
    logq.delete(); occ = 0; track = 1'b1;
    cnt[0] = 20; k[0] = '0; base[0] = 8'h80;
    checkIdle("t3_idle"); applyStimulus();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) begin
        checkBeat("t3_beat", 2'd0, 8'h80 + 8'(b * 4 + j)); applyStimulus();
      end
      checkIdle("t3_bubble"); applyStimulus();
    end
    for (int s = 0; s < 3; s++) begin
      checkOutput("t3_full", fifo_full, 1);
      checkOutput("t3_stall_wr", fifo_wr_en, 0);
      checkOutput("t3_stall_rdy", req_ready, 0);
      checkOutput("t3_stall_busy", busy, 1);
      checkOutput("t3_stall_gid", grant_id, 0);
      if (s == 2) pop = 1'b1;
      applyStimulus();
    end
    checkBeat("t3_resume", 2'd0, 8'h90); applyStimulus();
    checkOutput("t3_refull_wr", fifo_wr_en, 0);
    checkOutput("t3_logsize", logq.size(), 17);
    if (logq.size() == 17) checkOutput("t3_last", logq[16], 8'h90);
    cnt[0] = 0; track = 1'b0; occ = 0;
    applyStimulus();
    checkIdle("t3_end");

    $display("[TB] owner drops valid");
    doReset();
    cnt[1] = 2; base[1] = 8'h10; k[1] = '0;
    cnt[3] = 4; base[3] = 8'h30; k[3] = '0;
    checkIdle("t4_idle"); applyStimulus();
    checkBeat("t4_w0", 2'd1, 8'h10); applyStimulus();
    checkBeat("t4_w1", 2'd1, 8'h11); applyStimulus();
    cnt[0] = 1; k[0] = '0; base[0] = 8'h00;
    checkOutput("t4_drop_busy", busy, 1);
    checkOutput("t4_drop_wr", fifo_wr_en, 0);
    checkOutput("t4_drop_rdy", req_ready, 0);
    applyStimulus();
    checkIdle("t4_bubble"); applyStimulus();
    for (int j = 0; j < 4; j++) begin
      checkBeat("t4_r3", 2'd3, 8'h30 + 8'(j)); applyStimulus();
    end
    checkIdle("t4_bubble2"); applyStimulus();
    checkBeat("t4_r0", 2'd0, 8'h00); applyStimulus();
    checkOutput("t4_rel_busy", busy, 1);
    checkOutput("t4_rel_wr", fifo_wr_en, 0);
    applyStimulus();

    $display("[TB] reset mid-burst");
    cnt[3] = 4; k[3] = '0;
    checkIdle("t5_idle"); applyStimulus();
    checkBeat("t5_w0", 2'd3, 8'h30); applyStimulus();
    rst_ = 1'b1;
    #1;
    checkOutput("t5_rst_wr", fifo_wr_en, 0);
    checkOutput("t5_rst_rdy", req_ready, 0);
    checkOutput("t5_rst_din", fifo_din, 0);
    checkOutput("t5_rst_gid", grant_id, 0);
    checkOutput("t5_rst_busy", busy, 0);
    cnt[0] = 2; k[0] = '0;
    applyStimulus();
    rst_ = 1'b0;
    checkIdle("t5_post_idle"); applyStimulus();
    checkBeat("t5_regrant", 2'd0, 8'h00);
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    applyStimulus();
    applyStimulus();

    $display("[TB] three requester wrap");
    rd3 = {8'hC2, 8'hC1, 8'hC0};
    rv3 = 3'b100;
    checkOutput("t6_idle_busy", busy3, 0); applyStimulus();
    checkOutput("t6_gid", gid3, 2);
    checkOutput("t6_wr", wr3, 1);
    checkOutput("t6_din", din3, 8'hC2);
    checkOutput("t6_rdy", rr3, 3'b100);
    rv3 = 3'b101;
    applyStimulus();
    for (int j = 1; j < 4; j++) begin
      checkOutput("t6_burst_gid", gid3, 2);
      checkOutput("t6_burst_wr", wr3, 1);
      applyStimulus();
    end
    checkOutput("t6_bubble_busy", busy3, 0); applyStimulus();
    checkOutput("t6_wrap_gid", gid3, 0);
    checkOutput("t6_wrap_din", din3, 8'hC0);
    checkOutput("t6_wrap_rdy", rr3, 3'b001);
    checkOutput("t6_wrap_wr", wr3, 1);
    rv3 = '0;
    applyStimulus();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
